upc_scan_checker: RTL and testbench
===================================

UPC_SCAN_CHECKER -- requirements
Module: upc_scan_checker

Interface
REQ-001 SHALL have parameter CODE_W, default 3, giving the item code width; table depth is N = 2**CODE_W.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of each tally counter.
REQ-003 SHALL have parameter DISC_INIT, width N, default 8'b0110_1000; bit i is the reset-time discount flag of code i.
REQ-004 SHALL have parameter EXP_INIT, width N, default 8'b0011_0001; bit i is the reset-time expensive flag of code i.
REQ-005 SHALL have these ports:
 clk  in  1  sole clock, rising edge.
 reset  in  1  asynchronous, active-high.
 in_valid  in  1  item offered.
 in_ready  out  1  item accepted when in_valid and in_ready are both high.
 in_code  in  CODE_W  item code.
 in_mark  in  1  secret mark present.
 out_valid  out  1  result held.
 out_ready  in  1  result consumed when out_valid and out_ready are both high.
 out_code  out  CODE_W  code of the result.
 out_disc  out  1  discounted flag.
 out_stolen  out  1  stolen flag.
 alarm  out  1  high while in state ALARM.
 alarm_ack  in  1  single-cycle alarm clear.
 cfg_we  in  1  table write enable.
 cfg_addr  in  CODE_W  table entry to write.
 cfg_disc  in  1  discount flag to write.
 cfg_exp  in  1  expensive flag to write.
 cnt_clr  in  1  synchronous clear of all counters.
 item_cnt, disc_cnt, stolen_cnt  out  CNT_W  tallies.

Function
REQ-006 SHALL hold an N-entry table of {disc, exp} flags, loaded from DISC_INIT/EXP_INIT on reset.
REQ-007 SHALL write cfg_disc and cfg_exp into entry cfg_addr on a clk edge where cfg_we=1.
REQ-008 SHALL evaluate an accepted item as disc = table[in_code].disc and stolen = table[in_code].exp AND NOT in_mark.
REQ-009 SHALL use pre-write table contents when a cfg write and an item accept hit the same code on the same edge.
REQ-010 SHALL drive in_ready = (state==IDLE) AND (NOT out_valid OR out_ready).
REQ-011 SHALL register the result in a one-entry output register, so out_valid rises on the edge that accepts the item (latency 1).
REQ-012 SHALL hold out_code, out_disc and out_stolen stable while out_valid=1 and out_ready=0.
REQ-013 SHALL clear out_valid on a consume edge with no new accept, and reload it on a simultaneous consume and accept.
REQ-014 SHALL implement the FSM states IDLE and ALARM.
REQ-015 SHALL move IDLE->ALARM on the edge that accepts an item whose stolen flag is 1.
REQ-016 SHALL move ALARM->IDLE on the edge where alarm_ack=1; alarm_ack in IDLE has no effect.
REQ-017 SHALL still allow the output register to drain in ALARM, while accepting no new items.
REQ-018 SHALL increment item_cnt on every accept, disc_cnt on accepts with disc=1, and stolen_cnt on accepts with stolen=1.
REQ-019 SHALL saturate each counter at 2**CNT_W-1 with no wrap.
REQ-020 SHALL give cnt_clr priority over increment, so all counters read 0 after that edge.

Reset
REQ-021 SHALL, on reset assertion and without waiting for clk, force state=IDLE, out_valid=0, out_code=0, out_disc=0, out_stolen=0, alarm=0, all counters to 0, and the table to its init values.
REQ-022 SHALL discard any in-flight result and any pending alarm when reset is asserted mid-operation.
REQ-023 SHALL show in_ready=1 on the first cycle after reset deassertion.

Structure
REQ-024 SHALL take the FSM state enum (IDLE, ALARM) and the default DISC_INIT/EXP_INIT constants from shared package upc_pkg.
REQ-025 SHALL instantiate sub-module sat_counter (parameter W; ports clr, inc, count) three times.

Verification
REQ-026 Defaults; code 3'b011, mark 0 -> next cycle out_disc=1, out_stolen=0, alarm=0, item_cnt=1, disc_cnt=1.
REQ-027 Code 3'b101, mark 0 -> out_disc=1, out_stolen=1, alarm=1, in_ready=0; an offered item stays unaccepted until an alarm_ack pulse, after which in_ready=1 next cycle.
REQ-028 out_ready=0 with two items offered -> first result held stable, second not accepted; raising out_ready -> second result appears the cycle after the first is consumed.
REQ-029 cfg_we with addr 3'b010, exp=1 on the same edge an item with code 2, mark 0 is accepted -> out_stolen=0; the next code-2, mark-0 item -> out_stolen=1.
REQ-030 CNT_W=2; five unmarked code-0 items, each acked -> stolen_cnt=3 and stays 3; cnt_clr together with an accept -> all counters 0.
REQ-031 Reset pulse asserted mid-alarm while out_valid=1 -> alarm=0, out_valid=0, counters 0 immediately; table restored to EXP_INIT.

Source files
------------

// File: rtl/upc_pkg.sv
// Shared definitions for the UPC scan checker: FSM states and the
// power-on contents of the discount / expensive flag table.
package upc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ALARM = 1'b1
    } upc_state_e;

    // Bit i belongs to item code i.
    localparam logic [7:0] DISC_INIT_DEF = 8'b0110_1000;
    localparam logic [7:0] EXP_INIT_DEF  = 8'b0011_0001;

endpackage

// File: rtl/upc_scan_checker_if.sv
// Bus between the scanner front end and the checker: item input, result
// output, alarm handshake, table configuration and tallies.
interface upc_scan_checker_if #(
    parameter int CODE_W = 3,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              in_mark;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_disc;
    logic              out_stolen;
    logic              alarm;
    logic              alarm_ack;
    logic              cfg_we;
    logic [CODE_W-1:0] cfg_addr;
    logic              cfg_disc;
    logic              cfg_exp;
    logic              cnt_clr;
    logic [CNT_W-1:0]  item_cnt;
    logic [CNT_W-1:0]  disc_cnt;
    logic [CNT_W-1:0]  stolen_cnt;

    // Driver side (scanner / host).
    modport master (
        output in_valid, in_code, in_mark, out_ready, alarm_ack,
               cfg_we, cfg_addr, cfg_disc, cfg_exp, cnt_clr,
        input  in_ready, out_valid, out_code, out_disc, out_stolen, alarm,
               item_cnt, disc_cnt, stolen_cnt
    );

    // Checker side.
    modport slave (
        input  in_valid, in_code, in_mark, out_ready, alarm_ack,
               cfg_we, cfg_addr, cfg_disc, cfg_exp, cnt_clr,
        output in_ready, out_valid, out_code, out_disc, out_stolen, alarm,
               item_cnt, disc_cnt, stolen_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + ONE;
    end

endmodule

// File: rtl/upc_scan_checker.sv
// Checkout scan checker: looks up each accepted item in a flag table,
// flags discounted / stolen items through a one-entry result register,
// raises an alarm on a stolen item until acknowledged, and keeps tallies.
module upc_scan_checker
    import upc_pkg::*;
#(
    parameter int                   CODE_W    = 3,
    parameter int                   CNT_W     = 8,
    parameter logic [2**CODE_W-1:0] DISC_INIT = DISC_INIT_DEF,
    parameter logic [2**CODE_W-1:0] EXP_INIT  = EXP_INIT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    upc_scan_checker_if.slave  bus
);

    localparam int N = 2**CODE_W;

    logic [N-1:0]      r_disc_tbl;
    logic [N-1:0]      r_exp_tbl;
    upc_state_e        r_state;
    upc_state_e        w_state_nxt;
    logic              r_out_valid;
    logic [CODE_W-1:0] r_out_code;
    logic              r_out_disc;
    logic              r_out_stolen;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_disc;
    logic              w_stolen;

    // Lookup reads the registered table, so a same-edge cfg write is
    // only seen by later items.
    assign w_disc     = r_disc_tbl[bus.in_code];
    assign w_stolen   = r_exp_tbl[bus.in_code] & ~bus.in_mark;
    assign w_in_ready = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_code   = r_out_code;
    assign bus.out_disc   = r_out_disc;
    assign bus.out_stolen = r_out_stolen;
    assign bus.alarm      = (r_state == ALARM);

    // Flag table: init values on reset, single-entry config writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disc_tbl <= DISC_INIT;
            r_exp_tbl  <= EXP_INIT;
        end else if (bus.cfg_we) begin
            r_disc_tbl[bus.cfg_addr] <= bus.cfg_disc;
            r_exp_tbl[bus.cfg_addr]  <= bus.cfg_exp;
        end
    end

    // Result register: load on accept, otherwise drain when consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_code   <= '0;
            r_out_disc   <= 1'b0;
            r_out_stolen <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_code   <= bus.in_code;
            r_out_disc   <= w_disc;
            r_out_stolen <= w_stolen;
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state: a stolen accept trips the alarm, ack clears it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_stolen) w_state_nxt = ALARM;
            ALARM:   if (bus.alarm_ack)        w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_item_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.cnt_clr),
        .inc   (w_accept),
        .count (bus.item_cnt)
    );

    sat_counter #(.W(CNT_W)) u_disc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.cnt_clr),
        .inc   (w_accept && w_disc),
        .count (bus.disc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stolen_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.cnt_clr),
        .inc   (w_accept && w_stolen),
        .count (bus.stolen_cnt)
    );

endmodule

// File: tb/tb_upc_scan_checker.sv
// Directed bench for upc_scan_checker: a default-parameter instance for the
// main flows and a CNT_W=2 instance for counter saturation and clear.
module tb_upc_scan_checker;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    int   mdl_item;
    int   mdl_disc;
    int   mdl_stolen;

    typedef struct {
        logic [2:0] code;
        logic       mark;
        logic       e_disc;
        logic       e_stolen;
    } vec_t;

    vec_t vecs[8];

    upc_scan_checker_if #(.CODE_W(3), .CNT_W(8)) bus1 ();
    upc_scan_checker_if #(.CODE_W(3), .CNT_W(2)) bus2 ();

    upc_scan_checker #(.CODE_W(3), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    upc_scan_checker #(.CODE_W(3), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at negedge; one step = one rising edge, then back to negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, " item_cnt"},   32'(bus1.item_cnt),   32'(mdl_item));
        chk({tag, " disc_cnt"},   32'(bus1.disc_cnt),   32'(mdl_disc));
        chk({tag, " stolen_cnt"}, 32'(bus1.stolen_cnt), 32'(mdl_stolen));
    endtask

    // Offer one item with out_ready high and check the registered result.
    task automatic send1(input logic [2:0] c, input logic m, input logic ed,
                         input logic es, input string tag);
        chk({tag, " in_ready"}, 32'(bus1.in_ready), 32'd1);
        bus1.in_valid = 1'b1;
        bus1.in_code  = c;
        bus1.in_mark  = m;
        step();
        bus1.in_valid = 1'b0;
        mdl_item++;
        if (ed) mdl_disc++;
        if (es) mdl_stolen++;
        chk({tag, " out_valid"},  32'(bus1.out_valid),  32'd1);
        chk({tag, " out_code"},   32'(bus1.out_code),   32'(c));
        chk({tag, " out_disc"},   32'(bus1.out_disc),   32'(ed));
        chk({tag, " out_stolen"}, 32'(bus1.out_stolen), 32'(es));
        chk({tag, " alarm"},      32'(bus1.alarm),      32'(es));
        chk_cnts(tag);
        if (es) begin
            bus1.alarm_ack = 1'b1;
            step();
            bus1.alarm_ack = 1'b0;
            chk({tag, " alarm cleared"}, 32'(bus1.alarm), 32'd0);
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        mdl_item = 0; mdl_disc = 0; mdl_stolen = 0;

        // Defaults: disc bits {3,5,6}, exp bits {0,4,5}.
        vecs[0] = '{3'd3, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{3'd0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{3'd1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{3'd4, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{3'd5, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{3'd6, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{3'd7, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3'd2, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        bus1.in_valid = 0; bus1.in_code = 0; bus1.in_mark = 0; bus1.out_ready = 1;
        bus1.alarm_ack = 0; bus1.cfg_we = 0; bus1.cfg_addr = 0; bus1.cfg_disc = 0;
        bus1.cfg_exp = 0; bus1.cnt_clr = 0;
        bus2.in_valid = 0; bus2.in_code = 0; bus2.in_mark = 0; bus2.out_ready = 1;
        bus2.alarm_ack = 0; bus2.cfg_we = 0; bus2.cfg_addr = 0; bus2.cfg_disc = 0;
        bus2.cfg_exp = 0; bus2.cnt_clr = 0;

        // Reset values before any clock edge.
        #3;
        chk("rst out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst out_code",  32'(bus1.out_code),  32'd0);
        chk("rst alarm",     32'(bus1.alarm),     32'd0);
        chk_cnts("rst");

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post-rst in_ready", 32'(bus1.in_ready), 32'd1);

        // Table-driven single items.
        for (int i = 0; i < 8; i++)
            send1(vecs[i].code, vecs[i].mark, vecs[i].e_disc, vecs[i].e_stolen,
                  $sformatf("vec%0d", i));

        // Stolen item blocks intake until ack; output still drains.
        bus1.in_valid = 1'b1; bus1.in_code = 3'd5; bus1.in_mark = 1'b0;
        step();
        mdl_item++; mdl_disc++; mdl_stolen++;
        bus1.in_code = 3'd3;
        chk("alm out_disc",   32'(bus1.out_disc),   32'd1);
        chk("alm out_stolen", 32'(bus1.out_stolen), 32'd1);
        chk("alm alarm",      32'(bus1.alarm),      32'd1);
        chk("alm in_ready",   32'(bus1.in_ready),   32'd0);
        step();
        step();
        chk("alm blocked in_ready", 32'(bus1.in_ready),  32'd0);
        chk("alm drained",          32'(bus1.out_valid), 32'd0);
        chk_cnts("alm blocked");
        bus1.alarm_ack = 1'b1;
        step();
        bus1.alarm_ack = 1'b0;
        chk("ack alarm",    32'(bus1.alarm),    32'd0);
        chk("ack in_ready", 32'(bus1.in_ready), 32'd1);
        step();
        mdl_item++; mdl_disc++;
        bus1.in_valid = 1'b0;
        chk("after ack out_code", 32'(bus1.out_code), 32'd3);
        chk_cnts("after ack");
        bus1.alarm_ack = 1'b1;
        step();
        bus1.alarm_ack = 1'b0;
        chk("idle ack alarm", 32'(bus1.alarm), 32'd0);

        // Backpressure: first result held, second waits.
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_code = 3'd3; bus1.in_mark = 1'b0;
        step();
        mdl_item++; mdl_disc++;
        bus1.in_code = 3'd6;
        chk("bp in_ready", 32'(bus1.in_ready), 32'd0);
        step();
        chk("bp hold valid", 32'(bus1.out_valid), 32'd1);
        chk("bp hold code",  32'(bus1.out_code),  32'd3);
        chk("bp hold disc",  32'(bus1.out_disc),  32'd1);
        chk_cnts("bp hold");
        bus1.out_ready = 1'b1;
        step();
        mdl_item++; mdl_disc++;
        bus1.in_valid = 1'b0;
        chk("bp second valid", 32'(bus1.out_valid), 32'd1);
        chk("bp second code",  32'(bus1.out_code),  32'd6);
        chk_cnts("bp second");
        step();
        chk("bp drained", 32'(bus1.out_valid), 32'd0);

        // Same-edge cfg write vs. accept on code 2.
        bus1.cfg_we = 1'b1; bus1.cfg_addr = 3'd2; bus1.cfg_disc = 1'b0; bus1.cfg_exp = 1'b1;
        bus1.in_valid = 1'b1; bus1.in_code = 3'd2; bus1.in_mark = 1'b0;
        step();
        mdl_item++;
        bus1.cfg_we = 1'b0; bus1.in_valid = 1'b0;
        chk("cfg same-edge stolen", 32'(bus1.out_stolen), 32'd0);
        send1(3'd2, 1'b0, 1'b0, 1'b1, "cfg next");

        // Saturation and clear on the narrow instance.
        for (int k = 1; k <= 5; k++) begin
            bus2.in_valid = 1'b1; bus2.in_code = 3'd0; bus2.in_mark = 1'b0;
            step();
            bus2.in_valid = 1'b0;
            chk($sformatf("sat%0d alarm", k), 32'(bus2.alarm), 32'd1);
            chk($sformatf("sat%0d stolen_cnt", k), 32'(bus2.stolen_cnt), 32'((k > 3) ? 3 : k));
            bus2.alarm_ack = 1'b1;
            step();
            bus2.alarm_ack = 1'b0;
        end
        chk("sat item_cnt", 32'(bus2.item_cnt), 32'd3);
        chk("sat disc_cnt", 32'(bus2.disc_cnt), 32'd0);
        bus2.in_valid = 1'b1; bus2.in_code = 3'd3; bus2.cnt_clr = 1'b1;
        step();
        bus2.in_valid = 1'b0; bus2.cnt_clr = 1'b0;
        chk("clr item_cnt",   32'(bus2.item_cnt),   32'd0);
        chk("clr disc_cnt",   32'(bus2.disc_cnt),   32'd0);
        chk("clr stolen_cnt", 32'(bus2.stolen_cnt), 32'd0);
        chk("clr out_code",   32'(bus2.out_code),   32'd3);
        bus2.in_valid = 1'b1;
        step();
        bus2.in_valid = 1'b0;
        chk("post-clr item_cnt", 32'(bus2.item_cnt), 32'd1);
        chk("post-clr disc_cnt", 32'(bus2.disc_cnt), 32'd1);

        // Reset mid-alarm with a held result.
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_code = 3'd5; bus1.in_mark = 1'b0;
        step();
        bus1.in_valid = 1'b0;
        chk("pre-rst alarm",     32'(bus1.alarm),     32'd1);
        chk("pre-rst out_valid", 32'(bus1.out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        mdl_item = 0; mdl_disc = 0; mdl_stolen = 0;
        chk("midrst alarm",      32'(bus1.alarm),      32'd0);
        chk("midrst out_valid",  32'(bus1.out_valid),  32'd0);
        chk("midrst out_stolen", 32'(bus1.out_stolen), 32'd0);
        chk_cnts("midrst");
        @(negedge clk);
        reset = 1'b0;
        bus1.out_ready = 1'b1;
        #1;
        chk("midrst in_ready", 32'(bus1.in_ready), 32'd1);
        send1(3'd2, 1'b0, 1'b0, 1'b0, "restored code2");
        send1(3'd4, 1'b0, 1'b0, 1'b1, "restored code4");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
